// File: rtl/filtro_banda_ctrl.sv
// Coefficient bank and sample sequencer for the cascaded band-pass biquads.
// The host fills a shadow bank; a commit copies it to the active bank on a sample tick.
module filtro_banda_ctrl #(
  parameter int p     = 13,
  parameter int f     = 18,
  parameter int Width = p + f + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [3:0]              wr_addr,
  input  logic signed [Width-1:0] wr_data,
  input  logic                    commit_req,
  input  logic                    flush,
  input  logic                    sample_tick,
  output logic signed [Width-1:0] La1,
  output logic signed [Width-1:0] La2,
  output logic signed [Width-1:0] Lb0,
  output logic signed [Width-1:0] Lb1,
  output logic signed [Width-1:0] Lb2,
  output logic signed [Width-1:0] Ha1,
  output logic signed [Width-1:0] Ha2,
  output logic signed [Width-1:0] Hb0,
  output logic signed [Width-1:0] Hb1,
  output logic signed [Width-1:0] Hb2,
  output logic                    enable,
  output logic                    filt_clr,
  output logic                    pending,
  output logic                    commit_ack,
  output logic                    addr_err,
  output logic                    overrun
);

  localparam int NumCoef = 10;
  localparam logic signed [Width-1:0] Unity = Width'(1) << f;

  typedef enum logic [1:0] {StIdle, StClr, StRun} state_e;

  state_e state_q, state_d;

  logic signed [Width-1:0] shadow_q [NumCoef];
  logic signed [Width-1:0] active_q [NumCoef];

  logic pending_q, pending_d;
  logic flush_q, flush_d;
  logic commit_ack_q, addr_err_q, overrun_q;
  logic commit, wr_ok;

  assign commit = (state_q == StIdle) && sample_tick && pending_q;
  assign wr_ok  = wr_en && (wr_addr < 4'd10);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          state_d = (commit && flush_q) ? StClr : StRun;
        end
      end
      StClr:   state_d = StRun;
      StRun:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    enable   = 1'b0;
    filt_clr = 1'b0;
    unique case (state_q)
      StClr:   filt_clr = 1'b1;
      StRun:   enable   = 1'b1;
      default: ;
    endcase
  end

  // A commit consumes the request; a new request in the same cycle stays pending.
  always_comb begin
    pending_d = pending_q;
    flush_d   = flush_q;
    if (commit) begin
      pending_d = 1'b0;
      flush_d   = 1'b0;
    end
    if (commit_req) begin
      pending_d = 1'b1;
      flush_d   = flush_d | flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      flush_q      <= 1'b0;
      commit_ack_q <= 1'b0;
      addr_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      flush_q      <= flush_d;
      commit_ack_q <= commit;
      addr_err_q   <= wr_en && !wr_ok;
      if (sample_tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Active copies the pre-edge shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumCoef; i++) begin
        shadow_q[i] <= (i == 2 || i == 7) ? Unity : '0;
        active_q[i] <= (i == 2 || i == 7) ? Unity : '0;
      end
    end else begin
      for (int i = 0; i < NumCoef; i++) begin
        if (wr_ok && (wr_addr == 4'(i))) begin
          shadow_q[i] <= wr_data;
        end
        if (commit) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign La1 = active_q[0];
  assign La2 = active_q[1];
  assign Lb0 = active_q[2];
  assign Lb1 = active_q[3];
  assign Lb2 = active_q[4];
  assign Ha1 = active_q[5];
  assign Ha2 = active_q[6];
  assign Hb0 = active_q[7];
  assign Hb1 = active_q[8];
  assign Hb2 = active_q[9];

  assign pending    = pending_q;
  assign commit_ack = commit_ack_q;
  assign addr_err   = addr_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_filtro_banda_ctrl.sv
// Directed table-driven bench for filtro_banda_ctrl; one table row per clock cycle.
module tb_filtro_banda_ctrl;

  logic        clk, rst;
  logic        wr_en, commit_req, flush, sample_tick;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] La1, La2, Lb0, Lb1, Lb2, Ha1, Ha2, Hb0, Hb1, Hb2;
  logic        enable, filt_clr, pending, commit_ack, addr_err, overrun;
  logic [31:0] coef [10];

  int checks   = 0;
  int failures = 0;

  filtro_banda_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .flush(flush), .sample_tick(sample_tick),
    .La1(La1), .La2(La2), .Lb0(Lb0), .Lb1(Lb1), .Lb2(Lb2),
    .Ha1(Ha1), .Ha2(Ha2), .Hb0(Hb0), .Hb1(Hb1), .Hb2(Hb2),
    .enable(enable), .filt_clr(filt_clr), .pending(pending),
    .commit_ack(commit_ack), .addr_err(addr_err), .overrun(overrun)
  );

  assign coef[0] = La1;
  assign coef[1] = La2;
  assign coef[2] = Lb0;
  assign coef[3] = Lb1;
  assign coef[4] = Lb2;
  assign coef[5] = Ha1;
  assign coef[6] = Ha2;
  assign coef[7] = Hb0;
  assign coef[8] = Hb1;
  assign coef[9] = Hb2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        cr, fl, tk;
    logic [5:0]  flags; // {enable, filt_clr, pending, commit_ack, addr_err, overrun}
    int          ci;
    logic [31:0] cv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd, logic cr, logic fl,
                              logic tk, logic [5:0] flags, int ci, logic [31:0] cv);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.cr = cr; v.fl = fl; v.tk = tk;
    v.flags = flags; v.ci = ci; v.cv = cv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [3:0] wa, logic [31:0] wd, logic cr, logic fl, logic tk);
    wr_en = we; wr_addr = wa; wr_data = wd; commit_req = cr; flush = fl; sample_tick = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags_now();
    return {enable, filt_clr, pending, commit_ack, addr_err, overrun};
  endfunction

  task automatic chk_passthrough(string name);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s coef%0d", name, i), coef[i], (i == 2 || i == 7) ? 32'h0004_0000 : 32'h0);
    end
  endtask

  localparam logic [31:0] U = 32'h0004_0000;
  localparam logic [31:0] C1 = 32'h0001_2345;
  localparam logic [31:0] CN = 32'hFFFF_0000;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    chk("reset flags", 32'(flags_now()), 32'h0);
    chk_passthrough("reset");
    @(negedge clk);
    rst = 1'b0;
    #2;

    //                we wa  wd        cr fl tk  flags       ci cv
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100000, 2, U));   // plain tick
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 7, U));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100000, 0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 3, 0));
    vecs.push_back(mk(1, 3,  C1,       0, 0, 0, 6'b000000, 3, 0));   // Lb1 to shadow
    vecs.push_back(mk(0, 0,  0,        1, 0, 0, 6'b001000, 3, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b001000, 3, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b001000, 3, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b001000, 3, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b001000, 3, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100100, 3, C1));  // commit, no flush
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 3, C1));
    vecs.push_back(mk(1, 0,  CN,       0, 0, 0, 6'b000000, 0, 0));   // La1 negative
    vecs.push_back(mk(0, 0,  0,        1, 1, 0, 6'b001000, 0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b010100, 0, CN));  // commit + flush -> CLR
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b100000, 0, CN));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 2, U));
    vecs.push_back(mk(0, 0,  0,        1, 0, 0, 6'b001000, 6, 0));
    vecs.push_back(mk(1, 6,  32'h7,    0, 0, 1, 6'b100100, 6, 0));   // write during commit
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 6, 0));
    vecs.push_back(mk(0, 0,  0,        1, 0, 0, 6'b001000, 6, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100100, 6, 32'h7));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 7, U));
    vecs.push_back(mk(1, 12, 32'hDEAD, 0, 0, 0, 6'b000010, 6, 32'h7)); // bad address
    vecs.push_back(mk(0, 0,  0,        1, 0, 0, 6'b001000, 0, CN));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100100, 2, U));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 3, C1));
    vecs.push_back(mk(0, 0,  0,        1, 0, 1, 6'b101000, 6, 32'h7)); // req with tick
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b001000, 8, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100100, 9, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0,  0,        1, 1, 0, 6'b001000, 4, 0));   // merged request
    vecs.push_back(mk(0, 0,  0,        1, 0, 0, 6'b001000, 5, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b010100, 0, CN));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b100000, 3, C1));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000000, 3, C1));
    vecs.push_back(mk(0, 0,  0,        1, 1, 0, 6'b001000, 3, C1));  // overrun case
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b010100, 3, C1));
    vecs.push_back(mk(0, 0,  0,        0, 0, 1, 6'b100001, 3, C1));  // tick in CLR dropped
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000001, 3, C1));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0, 6'b000001, 3, C1));

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cr, vecs[i].fl, vecs[i].tk);
      step();
      chk($sformatf("row%0d flags", i), 32'(flags_now()), 32'(vecs[i].flags));
      chk($sformatf("row%0d coef%0d", i, vecs[i].ci), coef[vecs[i].ci], vecs[i].cv);
    end

    // Async reset in the middle of CLR with a new request already pending.
    drive(0, 0, 0, 1, 1, 0);
    step();
    drive(0, 0, 0, 1, 0, 1);
    step();
    chk("preclr flags", 32'(flags_now()), 32'(6'b011101));
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midclr rst flags", 32'(flags_now()), 32'h0);
    chk_passthrough("midclr rst");
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("post rst tick", 32'(flags_now()), 32'(6'b100000));
    drive(0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("post rst commit", 32'(flags_now()), 32'(6'b100100));
    chk_passthrough("post rst shadow");
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
